// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the CPU controller and a DMA/loader port.
// Each access holds its strobe for MEM_LAT cycles, then pulses a one-cycle ack with registered read data.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // IDLE   | sample requests, grant round-robin, strobes low
  // ACCESS | strobe held for MEM_LAT cycles, read data captured in the last one
  // DONE   | one-cycle ack to the owner, requests ignored
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DMA  = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                last_grant_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                cpu_ack_q;
  logic                dma_ack_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                busy_q;

  logic                grant_vld_d;
  logic                grant_dma_d;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // On a tie the side that was not served last wins.
  always_comb begin
    grant_vld_d = cpu_req | dma_req;
    grant_dma_d = dma_req & (~cpu_req | (last_grant_q == OWN_CPU));
    we_d        = grant_dma_d ? dma_we    : cpu_we;
    addr_d      = grant_dma_d ? dma_addr  : cpu_addr;
    wdata_d     = grant_dma_d ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= OWN_DMA;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            owner_q      <= grant_dma_d;
            last_grant_q <= grant_dma_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= '0;
            mem_read_q   <= ~we_d;
            mem_write_q  <= we_d;
            busy_q       <= 1'b1;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            if (!we_q) begin
              rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_ack_q   <= (owner_q == OWN_CPU);
            dma_ack_q   <= (owner_q == OWN_DMA);
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: a MEM_LAT=2 instance with a memory model and a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // main instance, MEM_LAT = 2
  logic          cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_ack, cpu_stall, dma_ack, mem_read, mem_write, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // second instance, MEM_LAT = 1, memory returns addr ^ 0xA5A50000
  logic          cpu_req1 = 0, dma_req1 = 0;
  logic [AW-1:0] cpu_addr1 = '0, dma_addr1 = '0;
  logic          cpu_ack1, cpu_stall1, dma_ack1, mem_read1, mem_write1, busy1;
  logic [DW-1:0] rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata('0),
    .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
    .dma_req(dma_req1), .dma_we(1'b0), .dma_addr(dma_addr1), .dma_wdata('0),
    .dma_ack(dma_ack1), .rdata(rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1), .mem_write(mem_write1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );
  assign mem_rdata1 = mem_read1 ? (mem_addr1 ^ 32'hA5A5_0000) : '0;

  // memory model for the main instance
  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hC0FFEE, a};
  endfunction

  logic [31:0] mem [256];
  bit   [255:0] wr_valid;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[7:0]]      <= mem_wdata;
      wr_valid[mem_addr[7:0]] <= 1'b1;
    end
  end
  assign mem_rdata = mem_read ? (wr_valid[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                                         : init_word(mem_addr[7:0])) : '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard
  typedef struct {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  int          ack_owner[$];
  int          ack_cyc[$];
  logic [31:0] ref_mem [256];
  exp_t        mon_e;

  task automatic push_exp(input bit is_dma, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.rd   = !we;
    e.data = ref_mem[a[7:0]];
    if (we) ref_mem[a[7:0]] = d;
    if (is_dma) dma_q.push_back(e);
    else        cpu_q.push_back(e);
  endtask

  task automatic cpu_go(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    push_exp(1'b0, we, a, d);
  endtask

  task automatic dma_go(input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
    push_exp(1'b1, we, a, d);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cpu_ack) begin
        ack_owner.push_back(0);
        ack_cyc.push_back(cyc);
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 1, 0);
        else begin
          mon_e = cpu_q.pop_front();
          if (mon_e.rd) chk("cpu_rdata", rdata, mon_e.data);
        end
      end
      if (dma_ack) begin
        ack_owner.push_back(1);
        ack_cyc.push_back(cyc);
        if (dma_q.size() == 0) chk("dma_unexpected_ack", 1, 0);
        else begin
          mon_e = dma_q.pop_front();
          if (mon_e.rd) chk("dma_rdata", rdata, mon_e.data);
        end
      end
      chk("strobe_excl", mem_read & mem_write, 0);
      chk("ack_excl", cpu_ack & dma_ack, 0);
    end
  end

  task automatic cpu_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input bit last);
    int n;
    cpu_go(we, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 40);
    if (!cpu_ack) chk("cpu_timeout", cpu_ack, 1);
    @(posedge clk); #1;
    if (last) cpu_req = 0;
  endtask

  task automatic dma_txn(input logic we, input logic [31:0] a, input logic [31:0] d, input bit last);
    int n;
    dma_go(we, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (!dma_ack && n < 40);
    if (!dma_ack) chk("dma_timeout", dma_ack, 1);
    @(posedge clk); #1;
    if (last) dma_req = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy1", busy1, 0);
    @(posedge clk); #1;
    rst = 1;
    cpu_q.delete();
    dma_q.delete();
  endtask

  // both sides request reads in the same cycle; CPU must win, DMA follows in the next IDLE
  task automatic tie_test(input string tag);
    @(posedge clk); #1;
    cpu_go(0, 32'h10, 0);
    dma_go(0, 32'h30, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk({tag, "_cpu_ack"}, cpu_ack, (k == 3));
      chk({tag, "_dma_ack"}, dma_ack, (k == 7));
      chk({tag, "_mem_read"}, mem_read, (k == 1 || k == 2 || k == 5 || k == 6));
      if (k == 1) chk({tag, "_addr_cpu"}, mem_addr, 32'h10);
      if (k == 5) chk({tag, "_addr_dma"}, mem_addr, 32'h30);
      @(posedge clk); #1;
      if (k == 3) cpu_req = 0;
      if (k == 7) dma_req = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    do_reset();

    // single CPU read
    @(posedge clk); #1;
    cpu_go(0, 32'h10, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_mem_read", mem_read, (k == 1 || k == 2));
      if (k == 1 || k == 2) chk("t1_mem_addr", mem_addr, 32'h10);
      chk("t1_cpu_ack", cpu_ack, (k == 3));
      chk("t1_cpu_stall", cpu_stall, (k < 3));
      chk("t1_busy", busy, (k >= 1 && k <= 3));
      if (k == 3) chk("t1_rdata", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      if (k == 3) cpu_req = 0;
    end

    // DMA write then CPU readback
    @(posedge clk); #1;
    dma_go(1, 32'h20, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_mem_write", mem_write, (k == 1 || k == 2));
      chk("t2_mem_read", mem_read, 0);
      if (k == 1 || k == 2) begin
        chk("t2_mem_addr", mem_addr, 32'h20);
        chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
      end
      chk("t2_dma_ack", dma_ack, (k == 3));
      chk("t2_cpu_ack", cpu_ack, 0);
      @(posedge clk); #1;
      if (k == 3) dma_req = 0;
    end
    cpu_txn(0, 32'h20, 0, 1);
    chk("t2_readback_q", ref_mem[8'h20], 32'h1234_5678);

    // tie right after reset
    do_reset();
    tie_test("t3");

    // continuous contention, 6 accesses
    ack_owner.delete();
    ack_cyc.delete();
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 3; i++) cpu_txn(0, 32'h40 + i, 0, i == 2);
      for (int i = 0; i < 3; i++) dma_txn(1, 32'h50 + i, 32'hA000_0000 + i, i == 2);
    join
    chk("t4_ack_count", ack_owner.size(), 6);
    for (int i = 0; i < ack_owner.size() && i < 6; i++) begin
      chk("t4_ack_order", ack_owner[i], i % 2);
      if (i > 0) chk("t4_ack_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    cpu_txn(0, 32'h51, 0, 1);

    // reset mid-access; last grant before reset was CPU
    @(posedge clk); #1;
    cpu_go(0, 32'h60, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_read_before_rst", mem_read, 1);
    @(posedge clk); #1;
    cpu_req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_mem_read", mem_read, 0);
      chk("t5_busy", busy, 0);
      chk("t5_cpu_ack", cpu_ack, 0);
      @(posedge clk); #1;
    end
    rst = 1;
    cpu_q.delete();
    dma_q.delete();
    tie_test("t5_tie");

    // MEM_LAT = 1 instance
    @(posedge clk); #1;
    cpu_req1 = 1; cpu_addr1 = 32'h44;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t6_mem_read", mem_read1, (k == 1 || k == 4));
      chk("t6_cpu_ack", cpu_ack1, (k == 2));
      chk("t6_dma_ack", dma_ack1, (k == 5));
      if (k == 1) chk("t6_addr_cpu", mem_addr1, 32'h44);
      if (k == 4) chk("t6_addr_dma", mem_addr1, 32'h88);
      if (k == 2) chk("t6_rdata_cpu", rdata1, 32'hA5A5_0044);
      if (k == 5) chk("t6_rdata_dma", rdata1, 32'hA5A5_0088);
      if (k == 3) chk("t6_busy_idle", busy1, 0);
      @(posedge clk); #1;
      if (k == 0) begin dma_req1 = 1; dma_addr1 = 32'h88; end
      if (k == 2) cpu_req1 = 0;
      if (k == 5) dma_req1 = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("dma_q_empty", dma_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
